serial_add_ctrl: RTL and testbench

//   Bit-serial adder sequencer. Adds two WIDTH-bit unsigned operands one bit per

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/half_adder.sv | 12 +
 rtl/serial_add_ctrl.sv | 109 ++++++++++
 tb/tb_serial_add_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding
// and the default operand width.
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/half_adder.sv
// One-bit half adder; two of these form the full-adder cell of the serial adder.
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: captures two operands on start, adds one bit per
// clock through a half-adder pair, then pulses done with {carry_out, sum}.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   result
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic p;
   logic g0;
   logic g1;
   logic s;
   logic c;

   half_adder ha0 (
      .a (sh_a[0]),
      .b (sh_b[0]),
      .s (p),
      .c (g0)
   );

   half_adder ha1 (
      .a (p),
      .b (carry),
      .s (s),
      .c (g1)
   );

   assign c = g0 | g1;

   // Accumulator with the current sum bit merged in at position cnt, so the
   // final edge can publish the complete sum without an extra cycle.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_acc
         assign acc_next[gi] = (cnt == CNT_W'(gi)) ? s : acc[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         sh_a   <= '0;
         sh_b   <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sh_a  <= op_a;
                  sh_b  <= op_b;
                  carry <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_ADD;
               end
            end
            S_ADD: begin
               acc   <= acc_next;
               carry <= c;
               sh_a  <= sh_a >> 1;
               sh_b  <= sh_b >> 1;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) begin
                  result <= {c, acc_next};
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: table of operand pairs at WIDTH=8 plus
// hand sequences for busy protection, mid-operation reset and a WIDTH=1 build.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         busy;
   logic         done;
   logic [W:0]   result;

   logic         start1;
   logic [0:0]   a1;
   logic [0:0]   b1;
   logic         busy1;
   logic         done1;
   logic [1:0]   result1;

   int n_cmp;
   int n_err;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W:0]   exp;
   } vec_t;

   vec_t vecs[8];

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   serial_add_ctrl #(.WIDTH(1)) dut_w1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start1),
      .op_a   (a1),
      .op_b   (b1),
      .busy   (busy1),
      .done   (done1),
      .result (result1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one operation and watch W+4 cycles after the accepting edge.
   // With inject set, a competing start (FF+FF) is pulsed mid-operation.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W:0] exp, input bit inject);
      int busy_cnt;
      int done_cnt;
      int done_at;
      @(negedge clk);
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      op_a     = ~a;
      op_b     = ~b;
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = -1;
      for (int i = 0; i < W + 4; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = i;
         end
         if (i == W) check("result", 32'(result), 32'(exp));
         if (inject && i == 3) begin
            start = 1'b1;
            op_a  = 8'hFF;
            op_b  = 8'hFF;
         end
         if (inject && i == 4) start = 1'b0;
      end
      check("busy_cycles", 32'(busy_cnt), 32'(W));
      check("done_pulses", 32'(done_cnt), 32'd1);
      check("done_latency", 32'(done_at), 32'(W));
      $display("op a=%02h b=%02h inject=%0d -> result=%03h (exp %03h)", a, b, inject, result, exp);
   endtask

   initial begin
      int done_cnt;
      int last;
      int pulses;
      int busy1_cnt;

      n_cmp  = 0;
      n_err  = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      op_a   = '0;
      op_b   = '0;
      start1 = 1'b0;
      a1     = '0;
      b1     = '0;

      vecs[0] = '{a: 8'h00, b: 8'h00, exp: 9'h000};
      vecs[1] = '{a: 8'hFF, b: 8'h01, exp: 9'h100};
      vecs[2] = '{a: 8'hA5, b: 8'h5A, exp: 9'h0FF};
      vecs[3] = '{a: 8'hFF, b: 8'hFF, exp: 9'h1FE};
      vecs[4] = '{a: 8'h12, b: 8'h34, exp: 9'h046};
      vecs[5] = '{a: 8'h7F, b: 8'h01, exp: 9'h080};
      vecs[6] = '{a: 8'h3C, b: 8'hC4, exp: 9'h100};
      vecs[7] = '{a: 8'h01, b: 8'h80, exp: 9'h081};

      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_w1_result", 32'(result1), 32'd0);
      $display("reset busy=%0d done=%0d result=%03h", busy, done, result);
      rst_n = 1'b1;

      for (int v = 0; v < 8; v++)
         run_op(vecs[v].a, vecs[v].b, vecs[v].exp, 1'b0);

      // Competing start while busy must be ignored.
      run_op(8'h12, 8'h34, 9'h046, 1'b1);

      // Asynchronous reset mid-operation aborts with no done pulse.
      @(negedge clk);
      start = 1'b1;
      op_a  = 8'h80;
      op_b  = 8'h80;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      $display("abort busy=%0d done=%0d result=%03h", busy, done, result);
      @(negedge clk);
      rst_n    = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(posedge clk);
         #1;
         if (done) done_cnt++;
      end
      check("abort_no_done", 32'(done_cnt), 32'd0);
      run_op(8'h80, 8'h80, 9'h100, 1'b0);

      // WIDTH=1 build with start held high: 1+1 back-to-back every 3 cycles.
      @(negedge clk);
      start1    = 1'b1;
      a1        = 1'b1;
      b1        = 1'b1;
      last      = -1;
      pulses    = 0;
      busy1_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (busy1) busy1_cnt++;
         if (done1) begin
            pulses++;
            check("w1_result", 32'(result1), 32'd2);
            if (last >= 0) check("w1_spacing", 32'(i - last), 32'd3);
            last = i;
            $display("w1 done at cycle %0d result=%02b", i, result1);
         end
      end
      start1 = 1'b0;
      check("w1_pulses", 32'(pulses), 32'd4);
      check("w1_busy_cycles", 32'(busy1_cnt), 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "bench timed out");
   end

endmodule
